rs_deinterleave_rx: RTL and testbench

Receive-side counterpart of the RS symbol distributor. It collects the four corrected RS(544,514) codewords A, B, C and D of one frame, which arrive one per cycle from the decoder. It strips the 30 parity symbols from each, re-interleaves the 10-bit message symbols back into the two 10280-bit AM-mapped flows, and presents them downstream with a valid/ready handshake. It sits between the RS decoder and the AM-removal / descrambler stage.

---
 rtl/rs_pkg.sv | 30 +++
 rtl/rs_deinterleave_rx_if.sv | 26 ++
 rtl/rs_cw_unpack.sv | 20 ++
 rtl/rs_deinterleave_rx.sv | 99 +++++++++
 tb/tb_rs_deinterleave_rx.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_pkg.sv
// Shared constants and types for the RS receive-side de-interleaver.
package rs_pkg;
    localparam int SYMBOL_WIDTH    = 10;
    localparam int CW_SYMBOLS      = 544;
    localparam int MSG_SYMBOLS     = 514;
    localparam int PARITY_SYMBOLS  = 30;
    localparam int WIDTH_WORD_RS   = CW_SYMBOLS * SYMBOL_WIDTH;
    localparam int MSG_WIDTH       = MSG_SYMBOLS * SYMBOL_WIDTH;
    localparam int AM_MAPPED_WIDTH = 2 * MSG_WIDTH;

    typedef enum logic [1:0] {CW_A, CW_B, CW_C, CW_D} cw_idx_e;

    typedef enum logic [2:0] {
        ST_WAIT_A, ST_WAIT_B, ST_WAIT_C, ST_WAIT_D, ST_PRESENT
    } rx_state_e;

    // WAIT_x state encodings are laid out so their low bits are the expected codeword tag.
    function automatic logic [1:0] expected_idx(rx_state_e s);
        return s[1:0];
    endfunction

    function automatic rx_state_e next_wait(rx_state_e s);
        case (s)
            ST_WAIT_A: return ST_WAIT_B;
            ST_WAIT_B: return ST_WAIT_C;
            ST_WAIT_C: return ST_WAIT_D;
            default:   return ST_PRESENT;
        endcase
    endfunction
endpackage

// File: rtl/rs_deinterleave_rx_if.sv
// Codeword-in / frame-out handshake bundle for rs_deinterleave_rx.
interface rs_deinterleave_rx_if;
    import rs_pkg::*;

    logic [WIDTH_WORD_RS-1:0]   i_word;
    logic [1:0]                 i_word_idx;
    logic                       i_uncorrectable;
    logic                       i_valid;
    logic                       o_ready;
    logic [AM_MAPPED_WIDTH-1:0] o_flow0;
    logic [AM_MAPPED_WIDTH-1:0] o_flow1;
    logic                       o_uncorr;
    logic                       o_valid;
    logic                       i_ready;
    logic                       o_err_seq;

    modport slave (
        input  i_word, i_word_idx, i_uncorrectable, i_valid, i_ready,
        output o_ready, o_flow0, o_flow1, o_uncorr, o_valid, o_err_seq
    );

    modport master (
        output i_word, i_word_idx, i_uncorrectable, i_valid, i_ready,
        input  o_ready, o_flow0, o_flow1, o_uncorr, o_valid, o_err_seq
    );
endinterface

// File: rtl/rs_cw_unpack.sv
// Pulls the 514 message symbols out of a codeword, symbol 0 at the LSBs.
module rs_cw_unpack
    import rs_pkg::*;
(
    input  logic [WIDTH_WORD_RS-1:0] i_word,
    output logic [MSG_WIDTH-1:0]     o_msg
);
    logic w_unused_parity;

    genvar l;
    generate
        for (l = 0; l < MSG_SYMBOLS; l++) begin : g_sym
            assign o_msg[l*SYMBOL_WIDTH +: SYMBOL_WIDTH] =
                i_word[(CW_SYMBOLS-l)*SYMBOL_WIDTH-1 -: SYMBOL_WIDTH];
        end
    endgenerate

    // Parity symbols were consumed by the decoder; nothing here needs them.
    assign w_unused_parity = ^i_word[PARITY_SYMBOLS*SYMBOL_WIDTH-1:0];
endmodule

// File: rtl/rs_deinterleave_rx.sv
// Collects codewords A..D, strips parity and re-interleaves message symbols
// into the two AM-mapped flows; the output registers double as frame buffer.
module rs_deinterleave_rx
    import rs_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    rs_deinterleave_rx_if.slave bus
);
    rx_state_e                  r_state;
    logic                       r_ready;
    logic                       r_valid;
    logic                       r_err_seq;
    logic                       r_uncorr;
    logic [AM_MAPPED_WIDTH-1:0] r_flow0;
    logic [AM_MAPPED_WIDTH-1:0] r_flow1;

    logic [MSG_WIDTH-1:0]       w_msg;
    cw_idx_e                    w_idx;
    logic                       w_in_order;
    logic                       w_wr;

    rs_cw_unpack u_unpack (
        .i_word (bus.i_word),
        .o_msg  (w_msg)
    );

    assign w_idx      = cw_idx_e'(bus.i_word_idx);
    assign w_in_order = (bus.i_word_idx == expected_idx(r_state));
    // An out-of-order A restarts the frame, so every written word lands in its own tag's slot.
    assign w_wr       = bus.i_valid && (r_state != ST_PRESENT) && (w_in_order || w_idx == CW_A);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_WAIT_A;
            r_ready   <= 1'b1;
            r_valid   <= 1'b0;
            r_err_seq <= 1'b0;
            r_uncorr  <= 1'b0;
        end else begin
            r_err_seq <= 1'b0;
            case (r_state)
                ST_PRESENT: begin
                    if (bus.i_ready) begin
                        r_state <= ST_WAIT_A;
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    if (bus.i_valid) begin
                        if (w_in_order) begin
                            r_uncorr <= (w_idx == CW_A) ? bus.i_uncorrectable
                                                        : (r_uncorr | bus.i_uncorrectable);
                            r_state  <= next_wait(r_state);
                            if (r_state == ST_WAIT_D) begin
                                r_valid <= 1'b1;
                                r_ready <= 1'b0;
                            end
                        end else begin
                            r_err_seq <= 1'b1;
                            if (w_idx == CW_A) begin
                                r_uncorr <= bus.i_uncorrectable;
                                r_state  <= ST_WAIT_B;
                            end else begin
                                r_uncorr <= 1'b0;
                                r_state  <= ST_WAIT_A;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // A/C fill even symbol slots, B/D the odd ones; unwritten slots keep the previous frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flow0 <= '0;
            r_flow1 <= '0;
        end else if (w_wr) begin
            for (int l = 0; l < MSG_SYMBOLS; l++) begin
                case (w_idx)
                    CW_A: r_flow0[(2*l)*SYMBOL_WIDTH   +: SYMBOL_WIDTH] <= w_msg[l*SYMBOL_WIDTH +: SYMBOL_WIDTH];
                    CW_B: r_flow0[(2*l+1)*SYMBOL_WIDTH +: SYMBOL_WIDTH] <= w_msg[l*SYMBOL_WIDTH +: SYMBOL_WIDTH];
                    CW_C: r_flow1[(2*l)*SYMBOL_WIDTH   +: SYMBOL_WIDTH] <= w_msg[l*SYMBOL_WIDTH +: SYMBOL_WIDTH];
                    CW_D: r_flow1[(2*l+1)*SYMBOL_WIDTH +: SYMBOL_WIDTH] <= w_msg[l*SYMBOL_WIDTH +: SYMBOL_WIDTH];
                endcase
            end
        end
    end

    assign bus.o_ready   = r_ready;
    assign bus.o_valid   = r_valid;
    assign bus.o_err_seq = r_err_seq;
    assign bus.o_uncorr  = r_uncorr;
    assign bus.o_flow0   = r_flow0;
    assign bus.o_flow1   = r_flow1;
endmodule

// File: tb/tb_rs_deinterleave_rx.sv
// Bench for rs_deinterleave_rx: directed frames plus random traffic against a word-level model.
module tb_rs_deinterleave_rx;
    import rs_pkg::*;

    typedef logic [WIDTH_WORD_RS-1:0]   word_t;
    typedef logic [AM_MAPPED_WIDTH-1:0] flow_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rs_deinterleave_rx_if bus();

    rs_deinterleave_rx dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: last accepted word per tag, frame phase 0..3 = waiting for tag, 4 = presenting.
    word_t m_word [4] = '{default: '0};
    int    m_phase = 0;
    logic  m_err = 1'b0;
    logic  m_unc = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_err   <= 1'b0;
            m_unc   <= 1'b0;
            for (int i = 0; i < 4; i++) m_word[i] <= '0;
        end else begin
            m_err <= 1'b0;
            if (m_phase == 4) begin
                if (bus.i_ready) m_phase <= 0;
            end else if (bus.i_valid) begin
                if (int'(bus.i_word_idx) == m_phase) begin
                    m_word[bus.i_word_idx] <= bus.i_word;
                    m_unc   <= (m_phase == 0) ? bus.i_uncorrectable : (m_unc | bus.i_uncorrectable);
                    m_phase <= m_phase + 1;
                end else begin
                    m_err <= 1'b1;
                    if (bus.i_word_idx == 2'd0) begin
                        m_word[0] <= bus.i_word;
                        m_unc     <= bus.i_uncorrectable;
                        m_phase   <= 1;
                    end else begin
                        m_unc   <= 1'b0;
                        m_phase <= 0;
                    end
                end
            end
        end
    end

    function automatic flow_t build_flow(word_t lo, word_t hi);
        flow_t f = '0;
        for (int l = 0; l < MSG_SYMBOLS; l++) begin
            f[20*l    +: 10] = lo[(CW_SYMBOLS-l)*10-1 -: 10];
            f[20*l+10 +: 10] = hi[(CW_SYMBOLS-l)*10-1 -: 10];
        end
        return f;
    endfunction

    // Symbol l of pattern k is (l + 100k) mod 1024; parity zero or random.
    function automatic word_t mk_word(int k, bit rand_par);
        word_t w = '0;
        for (int l = 0; l < CW_SYMBOLS; l++) begin
            if (l < MSG_SYMBOLS) w[(CW_SYMBOLS-l)*10-1 -: 10] = 10'((l + k*100) % 1024);
            else if (rand_par)   w[(CW_SYMBOLS-l)*10-1 -: 10] = 10'($urandom);
        end
        return w;
    endfunction

    function automatic word_t rnd_word();
        word_t w = '0;
        for (int i = 0; i < WIDTH_WORD_RS/32; i++) w[32*i +: 32] = $urandom;
        return w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk_flow(input string nm, input flow_t got, input flow_t exp);
        checks++;
        if (got !== exp) begin
            int s = 0;
            errors++;
            for (int l = 2*MSG_SYMBOLS-1; l >= 0; l--)
                if (got[l*10 +: 10] !== exp[l*10 +: 10]) s = l;
            $display("FAIL %s sym %0d got %0d exp %0d at %0t", nm, s, got[s*10 +: 10], exp[s*10 +: 10], $time);
        end
    endtask

    // One cycle: compare every output against the model at the falling edge, then release.
    task automatic tick();
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_valid", 32'(bus.o_valid), 0);
            chk("rst_err_seq", 32'(bus.o_err_seq), 0);
            chk("rst_uncorr", 32'(bus.o_uncorr), 0);
            chk_flow("rst_flow0", bus.o_flow0, '0);
            chk_flow("rst_flow1", bus.o_flow1, '0);
        end else begin
            chk("ready", 32'(bus.o_ready), 32'(m_phase != 4));
            chk("valid", 32'(bus.o_valid), 32'(m_phase == 4));
            chk("err_seq", 32'(bus.o_err_seq), 32'(m_err));
            if (m_phase == 4) begin
                chk_flow("flow0", bus.o_flow0, build_flow(m_word[0], m_word[1]));
                chk_flow("flow1", bus.o_flow1, build_flow(m_word[2], m_word[3]));
                chk("uncorr", 32'(bus.o_uncorr), 32'(m_unc));
            end
        end
        #2;
    endtask

    task automatic send(input logic [1:0] k, input word_t w, input logic u);
        bus.i_word          = w;
        bus.i_word_idx      = k;
        bus.i_uncorrectable = u;
        bus.i_valid         = 1'b1;
        tick();
        bus.i_valid         = 1'b0;
        bus.i_uncorrectable = 1'b0;
    endtask

    task automatic send_frame(input int base, input logic [3:0] unc, input bit rp);
        for (int k = 0; k < 4; k++) send(2'(k), mk_word(base + k, rp), unc[k]);
    endtask

    flow_t ref0, ref1, h0, h1;

    initial begin
        bus.i_word          = '0;
        bus.i_word_idx      = 2'd0;
        bus.i_uncorrectable = 1'b0;
        bus.i_valid         = 1'b0;
        bus.i_ready         = 1'b1;

        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("ready_after_reset", 32'(bus.o_ready), 1);

        // In-order frame
        send_frame(0, 4'b0000, 1'b0);
        chk("inorder_valid", 32'(bus.o_valid), 1);
        chk("f0_sym0", 32'(bus.o_flow0[9:0]), 0);
        chk("f0_sym1", 32'(bus.o_flow0[19:10]), 100);
        chk("f1_sym0", 32'(bus.o_flow1[9:0]), 200);
        chk("f1_sym1", 32'(bus.o_flow1[19:10]), 300);
        chk("f0_top", 32'(bus.o_flow0[10279:10270]), 613);
        chk("inorder_uncorr", 32'(bus.o_uncorr), 0);
        ref0 = bus.o_flow0;
        ref1 = bus.o_flow1;
        tick();
        chk("valid_drops", 32'(bus.o_valid), 0);

        // Parity must not affect the flows
        send_frame(0, 4'b0000, 1'b1);
        chk_flow("parity_flow0", bus.o_flow0, ref0);
        chk_flow("parity_flow1", bus.o_flow1, ref1);
        tick();

        // Backpressure: 7 cycles held, completes on the 8th
        bus.i_ready = 1'b0;
        send_frame(10, 4'b0000, 1'b0);
        h0 = bus.o_flow0;
        h1 = bus.o_flow1;
        chk("bp_f0_sym0", 32'(bus.o_flow0[9:0]), 1000);
        for (int i = 0; i < 7; i++) begin
            chk("bp_valid", 32'(bus.o_valid), 1);
            chk("bp_ready", 32'(bus.o_ready), 0);
            chk_flow("bp_hold0", bus.o_flow0, h0);
            chk_flow("bp_hold1", bus.o_flow1, h1);
            tick();
        end
        chk("bp_still_valid", 32'(bus.o_valid), 1);
        bus.i_ready = 1'b1;
        tick();
        chk("bp_done", 32'(bus.o_valid), 0);

        // Out of order A, C then a clean frame
        send(2'd0, mk_word(20, 1'b0), 1'b0);
        send(2'd2, mk_word(22, 1'b0), 1'b0);
        chk("ooo_err", 32'(bus.o_err_seq), 1);
        send_frame(30, 4'b0000, 1'b0);
        chk("ooo_f0_sym0", 32'(bus.o_flow0[9:0]), 952);
        tick();

        // A, B, A: second A restarts the frame
        send(2'd0, mk_word(40, 1'b0), 1'b0);
        send(2'd1, mk_word(41, 1'b0), 1'b0);
        send(2'd0, mk_word(50, 1'b0), 1'b0);
        chk("aba_err", 32'(bus.o_err_seq), 1);
        send(2'd1, mk_word(51, 1'b0), 1'b0);
        send(2'd2, mk_word(52, 1'b0), 1'b0);
        send(2'd3, mk_word(53, 1'b0), 1'b0);
        chk("aba_f0_sym0", 32'(bus.o_flow0[9:0]), 904);
        chk("aba_f0_sym1", 32'(bus.o_flow0[19:10]), 1004);
        tick();

        // Uncorrectable on C only, then a clean frame
        send_frame(60, 4'b0100, 1'b0);
        chk("uncorr_set", 32'(bus.o_uncorr), 1);
        tick();
        send_frame(61, 4'b0000, 1'b0);
        chk("uncorr_clear", 32'(bus.o_uncorr), 0);
        tick();

        // Reset after B discards the partial frame
        send(2'd0, mk_word(65, 1'b0), 1'b0);
        send(2'd1, mk_word(66, 1'b0), 1'b0);
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        send_frame(70, 4'b0000, 1'b0);
        chk("rst_f0_sym0", 32'(bus.o_flow0[9:0]), 856);
        chk("rst_f1_sym0", 32'(bus.o_flow1[9:0]), 32);
        tick();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            bus.i_valid         = ($urandom_range(3) != 0);
            bus.i_word          = rnd_word();
            bus.i_uncorrectable = ($urandom_range(7) == 0);
            bus.i_ready         = ($urandom_range(2) != 0);
            if ($urandom_range(5) == 0 || m_phase == 4) bus.i_word_idx = 2'($urandom_range(3));
            else                                        bus.i_word_idx = 2'(m_phase);
            tick();
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
